// File: rtl/video_pkg.sv
// Shared video pipeline types: OAM entry layout, sprite slot format and sizing constants.
package video_pkg;

  localparam int unsigned OAM_DEPTH = 64;
  localparam int unsigned MAX_SPR   = 4;
  localparam int unsigned SPR_H     = 16;
  localparam int unsigned ADDR_W    = $clog2(OAM_DEPTH);
  localparam int unsigned COORD_W   = 10;
  localparam int unsigned CNT_W     = $clog2(MAX_SPR + 1);

  typedef struct packed {
    logic               en;
    logic [COORD_W-1:0] x;
    logic [COORD_W-1:0] y;
    logic [7:0]         tile;
    logic               hflip;
    logic               vflip;
    logic               prio;
  } oam_entry_t;

  typedef struct packed {
    logic              valid;
    logic [1:0]        rsvd;
    logic [ADDR_W-1:0] idx;
  } slot_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_START,
    ST_SCAN,
    ST_DONE
  } state_e;

endpackage

// File: rtl/sprite_line_prepare_if.sv
// OAM read port, line request and per-line sprite slot results.
interface sprite_line_prepare_if;
  import video_pkg::*;

  logic [31:0]                 oam_data;
  logic [COORD_W-1:0]          sx;
  logic [COORD_W-1:0]          sy;
  logic [ADDR_W-1:0]           oam_addr;
  slot_t [MAX_SPR-1:0]         BufferArray;
  logic                        line_prepeared;

  modport master (
    input  oam_data, sx, sy,
    output oam_addr, BufferArray, line_prepeared
  );

  modport slave (
    output oam_data, sx, sy,
    input  oam_addr, BufferArray, line_prepeared
  );

endinterface

// File: rtl/sprite_line_prepare.sv
// Per-scanline sprite evaluator: scans OAM for line sy and buffers the first MAX_SPR
// sprites whose vertical span covers it, then raises line_prepeared.
module sprite_line_prepare
  import video_pkg::*;
(
  input  logic                  clk,
  input  logic                  reset,
  sprite_line_prepare_if.master bus
);

  localparam int unsigned SCAN_W = ADDR_W + 1;
  localparam int unsigned SEL_W  = $clog2(MAX_SPR);

  state_e              state_q, state_d;
  logic [COORD_W-1:0]  sy_q, sy_d;
  logic [ADDR_W-1:0]   oam_addr_q, oam_addr_d;
  logic [SCAN_W-1:0]   scan_q, scan_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  slot_t [MAX_SPR-1:0] slots_q, slots_d;
  logic                done_q, done_d;

  oam_entry_t          entry_c;
  logic [COORD_W:0]    diff_c;
  logic [ADDR_W-1:0]   eval_idx_c;
  logic                hit_c, eval_c, last_c, full_c, line_chg_c;
  logic                entry_unused;

  // scan_q counts presented addresses; data for address scan_q-1 is on oam_data now
  assign entry_c    = oam_entry_t'(bus.oam_data);
  assign diff_c     = {1'b0, sy_q} - {1'b0, entry_c.y};
  assign hit_c      = entry_c.en & ~diff_c[COORD_W] & (diff_c[COORD_W-1:0] < COORD_W'(SPR_H));
  assign eval_c     = (scan_q != '0);
  assign last_c     = (scan_q == SCAN_W'(OAM_DEPTH));
  assign full_c     = (cnt_q == CNT_W'(MAX_SPR - 1));
  assign line_chg_c = (bus.sy != sy_q);
  assign eval_idx_c = ADDR_W'(scan_q - SCAN_W'(1));

  assign entry_unused = ^{bus.sx, entry_c.x, entry_c.tile, entry_c.hflip, entry_c.vflip,
                          entry_c.prio};

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= ST_START;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      sy_q       <= '0;
      oam_addr_q <= '0;
      scan_q     <= '0;
      cnt_q      <= '0;
      slots_q    <= '0;
      done_q     <= 1'b0;
    end else begin
      sy_q       <= sy_d;
      oam_addr_q <= oam_addr_d;
      scan_q     <= scan_d;
      cnt_q      <= cnt_d;
      slots_q    <= slots_d;
      done_q     <= done_d;
    end
  end

  // A line change during the scan restarts it so partial results are never flagged
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (line_chg_c) state_d = ST_START;
      ST_START: state_d = ST_SCAN;
      ST_SCAN: begin
        if (line_chg_c) begin
          state_d = ST_START;
        end else if (eval_c && ((hit_c && full_c) || last_c)) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    sy_d       = sy_q;
    oam_addr_d = oam_addr_q;
    scan_d     = scan_q;
    cnt_d      = cnt_q;
    slots_d    = slots_q;
    done_d     = done_q;
    case (state_q)
      ST_START: begin
        sy_d       = bus.sy;
        oam_addr_d = '0;
        scan_d     = '0;
        cnt_d      = '0;
        slots_d    = '0;
        done_d     = 1'b0;
      end
      ST_SCAN: begin
        if (!line_chg_c) begin
          scan_d = scan_q + SCAN_W'(1);
          if (oam_addr_q != ADDR_W'(OAM_DEPTH - 1)) begin
            oam_addr_d = oam_addr_q + ADDR_W'(1);
          end
          if (eval_c && hit_c) begin
            slots_d[cnt_q[SEL_W-1:0]] = '{valid: 1'b1, rsvd: 2'b00, idx: eval_idx_c};
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      ST_DONE:  done_d = 1'b1;
      default:  ;
    endcase
  end

  assign bus.oam_addr       = oam_addr_q;
  assign bus.BufferArray    = slots_q;
  assign bus.line_prepeared = done_q;

endmodule

// File: tb/tb_sprite_line_prepare.sv
// Directed and randomized line scans against a list-based sprite selection model.
module tb_sprite_line_prepare;
  import video_pkg::*;

  logic clk = 1'b0;
  logic reset;

  sprite_line_prepare_if bus ();

  sprite_line_prepare dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.master)
  );

  always #5 clk = ~clk;

  logic [31:0] oam_mem [OAM_DEPTH];
  logic [8:0]  exp_slots [MAX_SPR];
  int          n_cmp = 0;
  int          n_err = 0;

  // Synchronous OAM: data for an address appears one cycle later
  always @(posedge clk) bus.oam_data <= oam_mem[bus.oam_addr];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // First MAX_SPR enabled entries, in index order, with Y <= line <= Y+SPR_H-1
  task automatic model(input int line);
    int n = 0;
    for (int k = 0; k < MAX_SPR; k++) exp_slots[k] = '0;
    for (int i = 0; i < OAM_DEPTH; i++) begin
      int y = int'(oam_mem[i][20:11]);
      if (oam_mem[i][31] && line >= y && line <= y + SPR_H - 1 && n < MAX_SPR) begin
        exp_slots[n] = 9'(256 + i);
        n++;
      end
    end
  endtask

  task automatic wait_flag(input logic val, input int budget, input string tag);
    int k = 0;
    while (bus.line_prepeared !== val && k < budget) begin
      @(negedge clk);
      k++;
    end
    chk(tag, 32'(bus.line_prepeared), 32'(val));
  endtask

  task automatic check_slots(input int line, input string tag);
    model(line);
    for (int k = 0; k < MAX_SPR; k++)
      chk($sformatf("%s slot%0d", tag, k), 32'(bus.BufferArray[k]), 32'(exp_slots[k]));
  endtask

  task automatic run_line(input int line, input string tag);
    @(negedge clk);
    bus.sy = 10'(line);
    wait_flag(1'b0, 3, {tag, " drop"});
    wait_flag(1'b1, 80, {tag, " done"});
    check_slots(line, tag);
  endtask

  task automatic clear_mem();
    for (int i = 0; i < OAM_DEPTH; i++) oam_mem[i] = 32'h0;
  endtask

  task automatic put(input int idx, input int y);
    oam_mem[idx] = 32'h8000_0000 | (32'(y) << 11) | ($urandom & 32'h0000_07FF);
  endtask

  initial begin
    int prev_sy;
    int span;
    int line;

    reset  = 1'b0;
    bus.sy = '0;
    bus.sx = 10'($urandom);
    for (int i = 0; i < OAM_DEPTH; i++) oam_mem[i] = 32'h8000_0000;

    @(negedge clk);
    chk("reset flag", 32'(bus.line_prepeared), 32'h0);
    chk("reset addr", 32'(bus.oam_addr), 32'h0);
    chk("reset slots", 32'(bus.BufferArray), 32'h0);
    reset = 1'b1;
    wait_flag(1'b1, 10, "post-reset done");
    check_slots(0, "post-reset");

    run_line(15, "sy15");
    run_line(16, "sy16");

    clear_mem();
    run_line(0, "disabled");

    clear_mem();
    put(5, 100);
    put(63, 100);
    run_line(100, "idx5_63");

    clear_mem();
    put(0, 201);
    put(1, 184);
    put(2, 185);
    put(3, 200);
    run_line(200, "span edges");

    clear_mem();
    put(10, 1020);
    put(11, 0);
    run_line(3, "no wrap");

    clear_mem();
    put(2, 305);
    put(50, 305);
    for (int i = 40; i < 45; i++) put(i, 300);
    @(negedge clk);
    bus.sy = 10'd300;
    repeat (20) @(negedge clk);
    chk("midscan busy", 32'(bus.line_prepeared), 32'h0);
    bus.sy = 10'd310;
    wait_flag(1'b1, 80, "midscan done");
    check_slots(310, "midscan");

    prev_sy = 310;
    for (int it = 0; it < 8; it++) begin
      span = 80 + it * 110;
      for (int i = 0; i < OAM_DEPTH; i++) begin
        oam_mem[i] = $urandom;
        oam_mem[i][20:11] = 10'($urandom_range(0, span));
      end
      do line = $urandom_range(0, span + 20); while (line == prev_sy);
      prev_sy = line;
      bus.sx = 10'($urandom);
      run_line(line, $sformatf("rand%0d", it));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
